muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 15 +
 rtl/muldiv_div_step.sv | 23 ++
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done handshake plus operands and result of the multiply/divide unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-divide step: shift in a dividend bit, subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted - {1'b0, divisor};
    // Top bit of the difference is the borrow: clear means the divisor fit.
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (32 steps + result cycle).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier on MUL* ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Operand conditioning at accept time.
  logic            signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    signed_a = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV) || (bus.op == OP_REM);
    signed_b = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
               (bus.op == OP_DIV) || (bus.op == OP_REM);
    sa    = signed_a & bus.a[XLEN-1];
    sb    = signed_b & bus.b[XLEN-1];
    mag_a = sa ? -bus.a : bus.a;
    mag_b = sb ? -bus.b : bus.b;
  end

  // Multiply step: multiplier sits in the low half of acc and shifts out as the product shifts in.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN-1:0]   rem_next;
  logic              q_bit;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_next = {rem_next, acc_q[XLEN-2:0], q_bit};
  end

  muldiv_div_step #(
    .W (XLEN)
  ) u_div_step (
    .rem      (acc_q[2*XLEN-1:XLEN]),
    .dvd_bit  (acc_q[XLEN-1]),
    .divisor  (opnd_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Sign fixup and result selection.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, fix_res;

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quot    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remv    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res = '0;
    unique case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = div0_q ? DIV0_QUOT : (ovf_q ? INT_MIN : quot);
      OP_REM, OP_REMU:              fix_res = ovf_q ? '0 : remv;
      default:                      fix_res = '0;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic                   fast_q, fast_d;
  logic signed [XLEN:0]   fa, fb;
  logic signed [2*XLEN-1:0] fprod;
  logic [XLEN-1:0]        fast_res;

  always_comb begin
    fa       = {signed_a & bus.a[XLEN-1], bus.a};
    fb       = {signed_b & bus.b[XLEN-1], bus.b};
    fprod    = fa * fb;
    fast_res = (bus.op == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fast_d   = fast_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          neg_d   = (bus.op == OP_REM) ? sa : (sa ^ sb);
          div0_d  = bus.op[2] && (bus.b == '0);
          ovf_d   = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.a == INT_MIN) && (bus.b == '1);
          cnt_d   = '0;
          opnd_d  = bus.op[2] ? mag_b : mag_a;
          acc_d   = {{XLEN{1'b0}}, (bus.op[2] ? mag_a : mag_b)};
          state_d = ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
          fast_d = ~bus.op[2];
          if (!bus.op[2]) begin
            result_d = fast_res;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef MULDIV_FAST_MUL_EN
        if (!fast_q) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
`else
        result_d = fix_res;
        done_d   = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fast_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef MULDIV_FAST_MUL_EN
      fast_q   <= fast_d;
`endif
    end
  end

  assign bus.busy   = (state_q == ST_CALC);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random ops through a result scoreboard.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] sb_q[$];

  muldiv_if bus ();

  muldiv_unit #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0]        ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    p  = '0;
    case (o)
      OP_MUL:    begin p = sx * sy; return p[31:0]; end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * $signed(uy); return p[63:32]; end
      OP_MULHU:  begin p = ux * uy; return p[63:32]; end
      OP_DIV: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(x) / $signed(y);
      end
      OP_DIVU: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 32'h0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 32'h0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, waits for done, pops the scoreboard and compares.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit chk_lat);
    int n;
    int busy_n;
    logic [31:0] exp;
    sb_q.push_back(ref_md(o, x, y));
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n      = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      n++;
    end
    exp = sb_q.pop_front();
    check({tag, "_timeout"}, 32'(n < 100), 32'd1);
    check(tag, bus.result, exp);
    if (chk_lat) begin
      check({tag, "_latency"}, 32'(n), 32'd33);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
      check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
      tick();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_held"}, bus.result, exp);
    end else begin
      tick();
    end
  endtask

  initial begin
    int n;
    logic [31:0] r;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
    check("mul_7_m3_const", bus.result, 32'hFFFF_FFEB);
    run_op("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhu_ff_const", bus.result, 32'hFFFF_FFFE);
    run_op("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhsu_ff_const", bus.result, 32'hFFFF_FFFF);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_m7_2_const", bus.result, 32'hFFFF_FFFD);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("rem_m7_2_const", bus.result, 32'hFFFF_FFFF);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_100_7_const", bus.result, 32'd14);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0);
    check("remu_100_7_const", bus.result, 32'd2);
    run_op("div_by0", OP_DIV, 32'h1234, 32'h0, 1'b1);
    check("div_by0_const", bus.result, DIV0_QUOT);
    run_op("rem_by0", OP_REM, 32'h1234, 32'h0, 1'b0);
    check("rem_by0_const", bus.result, 32'h1234);
    run_op("divu_by0", OP_DIVU, 32'h8000_0001, 32'h0, 1'b0);
    run_op("remu_by0", OP_REMU, 32'h8000_0001, 32'h0, 1'b0);
    run_op("div_ovf", OP_DIV, INT_MIN, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_const", bus.result, INT_MIN);
    run_op("rem_ovf", OP_REM, INT_MIN, 32'hFFFF_FFFF, 1'b0);
    check("rem_ovf_const", bus.result, 32'h0);
    run_op("mulh_min", OP_MULH, INT_MIN, INT_MIN, 1'b0);
    run_op("rem_neg_neg", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op("random", ro, ra, rb, 1'b0);
    end

    // A second start while busy must be ignored.
    sb_q.push_back(ref_md(OP_DIVU, 32'd100, 32'd7));
    bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.op = OP_MUL; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 10;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("restart_latency", 32'(n), 32'd33);
    r = sb_q.pop_front();
    check("restart_ignored", bus.result, r);
    repeat (4) tick();
    check("restart_no_second_op", 32'(bus.busy | bus.done), 32'd0);
    check("result_held", bus.result, r);

    // Asynchronous reset in the middle of a divide.
    bus.op = OP_DIV; bus.a = 32'h0000_7777; bus.b = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'h0);
    repeat (2) tick();
    check("abort_no_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 1'b1);
    check("mul_3_4_const", bus.result, 32'd12);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
